quad_step_decoder: RTL

- Converts a 2-channel quadrature input (A, B) from an external incremental encoder into single-cycle Up/Down step strobes for the 5-bit loadable up/down counter.
- Is the producer side of that counter's Up/Down command interface.
- Synchronizes and glitch-filters the asynchronous inputs, decodes Gray-code transitions, and flags and counts illegal (double-bit) transitions.

---
 rtl/quad_step_decoder_if.sv | 23 ++
 rtl/quad_step_decoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder_if.sv
// Up/Down command interface of the quadrature step decoder, plus its encoder inputs and status.
// The decoder drives the step strobes, so it takes the master side.
interface quad_step_decoder_if;
    logic       A;
    logic       B;
    logic       Clr;
    logic       Ready;
    logic       Up;
    logic       Down;
    logic       Dir;
    logic       Err;
    logic [3:0] Err_Cnt;

    modport master (
        input  A, B, Clr,
        output Ready, Up, Down, Dir, Err, Err_Cnt
    );

    modport slave (
        output A, B, Clr,
        input  Ready, Up, Down, Dir, Err, Err_Cnt
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters A/B, decodes Gray-code steps into
// single-cycle Up/Down strobes, and flags and counts illegal double-bit transitions.
module quad_step_decoder #(
    parameter int FILT_CYC    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    quad_step_decoder_if.master bus
);

    typedef enum logic [1:0] {INIT, SEED, RUN} state_t;

    state_t                 state, state_nxt;
    logic                   ready_c;
    logic [2:0]             init_cnt;
    logic                   init_done;

    logic [SYNC_STAGES-1:0] sync_a_p0, sync_b_p0;
    logic                   s_a, s_b;
    logic [3:0]             cnt_a, cnt_b;
    logic                   f_a, f_b;
    logic [1:0]             prev;
    logic [1:0]             cur;
    logic [1:0]             chg;
    logic                   step_fwd, step_rev, step_err;

    logic                   up_p1, down_p1, err_p1;
    logic                   dir_q;
    logic [3:0]             err_cnt_q;

    // Forward order on {A,B} is 00->10->11->01->00: A moves to the inverse of the old B,
    // or B moves to the old A.
    function automatic logic is_fwd(input logic [1:0] p, input logic [1:0] c);
        logic [1:0] d;
        d = p ^ c;
        return ((d == 2'b10) && (c[1] != p[0])) || ((d == 2'b01) && (c[0] == p[1]));
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Returns {next filtered level, next counter}.
    function automatic logic [4:0] filt_next(input logic s, input logic f, input logic [3:0] c);
        if (s == f)
            return {f, 4'd0};
        else if (c == 4'(FILT_CYC - 1))
            return {s, 4'd0};
        else
            return {f, c + 4'd1};
    endfunction

    assign s_a       = sync_a_p0[SYNC_STAGES-1];
    assign s_b       = sync_b_p0[SYNC_STAGES-1];
    assign init_done = (init_cnt == 3'(SYNC_STAGES - 1));

    assign cur      = {f_a, f_b};
    assign chg      = cur ^ prev;
    assign step_err = &chg;
    assign step_fwd = is_fwd(prev, cur);
    assign step_rev = (^chg) & ~step_fwd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= INIT;
            init_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            init_cnt <= (state == INIT) ? init_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        case (state)
            INIT:    if (init_done) state_nxt = SEED;
            SEED:    state_nxt = RUN;
            RUN:     ready_c = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    // Synchronizer and filter stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a_p0 <= '0;
            sync_b_p0 <= '0;
            f_a       <= 1'b0;
            f_b       <= 1'b0;
            cnt_a     <= 4'd0;
            cnt_b     <= 4'd0;
            prev      <= 2'b00;
        end else begin
            sync_a_p0 <= {sync_a_p0[SYNC_STAGES-2:0], bus.A};
            sync_b_p0 <= {sync_b_p0[SYNC_STAGES-2:0], bus.B};
            case (state)
                SEED: begin
                    f_a   <= s_a;
                    f_b   <= s_b;
                    cnt_a <= 4'd0;
                    cnt_b <= 4'd0;
                    prev  <= {s_a, s_b};
                end
                RUN: begin
                    {f_a, cnt_a} <= filt_next(s_a, f_a, cnt_a);
                    {f_b, cnt_b} <= filt_next(s_b, f_b, cnt_b);
                    prev         <= cur;
                end
                default: ;
            endcase
        end
    end

    // Decode stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            up_p1     <= 1'b0;
            down_p1   <= 1'b0;
            err_p1    <= 1'b0;
            dir_q     <= 1'b0;
            err_cnt_q <= 4'd0;
        end else begin
            up_p1   <= (state == RUN) && step_fwd;
            down_p1 <= (state == RUN) && step_rev;
            err_p1  <= (state == RUN) && step_err;
            if (bus.Clr) begin
                dir_q     <= 1'b0;
                err_cnt_q <= 4'd0;
            end else if (state == RUN) begin
                if (step_fwd)
                    dir_q <= 1'b1;
                else if (step_rev)
                    dir_q <= 1'b0;
                if (step_err)
                    err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign bus.Ready   = ready_c;
    assign bus.Up      = up_p1;
    assign bus.Down    = down_p1;
    assign bus.Err     = err_p1;
    assign bus.Dir     = dir_q;
    assign bus.Err_Cnt = err_cnt_q;

endmodule
